modulo_counter_monitor: RTL

- Checker/measurement stage directly downstream of the 8-bit modulo-N counter.
- Samples the counter value every clock and verifies that it advances 0, 1, … N-1, 0.
- On each legal wrap, reports the measured period through a valid/ready handshake and counts wraps. Any sequence break raises sticky error flags.
- Used both as an in-system health monitor and as a self-checking companion for counter benches.

---
 rtl/modulo_counter_monitor_if.sv | 10 +
 rtl/modulo_counter_monitor.sv | 135 +++++++++++++
 2 files changed

// File: rtl/modulo_counter_monitor_if.sv
// Period reporting channel of the modulo counter monitor: a one-word
// valid/ready handshake carrying the measured wrap period.
interface modulo_counter_monitor_if;
    logic [8:0] period;
    logic       period_valid;
    logic       period_ready;

    modport master (output period, output period_valid, input period_ready);
    modport slave  (input period, input period_valid, output period_ready);
endinterface

// File: rtl/modulo_counter_monitor.sv
// Sequence checker for an upstream 8-bit modulo-N counter: tracks 0..N-1,0
// progressions, reports each legal wrap period and raises sticky error flags.
module modulo_counter_monitor #(
    parameter int N             = 10,
    parameter bit STOP_ON_ERROR = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      counter,
    modulo_counter_monitor_if.master        period_bus,
    output logic [15:0]                     wrap_count,
    output logic                            seq_error,
    output logic                            overrun,
    output logic [1:0]                      state
);
    localparam logic [1:0] SYNC  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;
    localparam logic [7:0] LAST  = 8'(N - 1);
    localparam logic [8:0] N_EXT = 9'(N);

    logic [1:0]  state_r,      state_s;
    logic [7:0]  prev_r,       prev_s;
    logic [8:0]  run_len_r,    run_len_s;
    logic [8:0]  period_r,     period_s;
    logic        valid_r,      valid_s;
    logic [15:0] wrap_count_r, wrap_count_s;
    logic        seq_error_r,  seq_error_s;
    logic        overrun_r,    overrun_s;
    logic        accept_s;
    logic        wrap_s;
    logic        inc_ok_s;

    // Next-state computation: sequence tracking, holding register and counters.
    always_comb begin
        state_s      = state_r;
        prev_s       = prev_r;
        run_len_s    = run_len_r;
        period_s     = period_r;
        valid_s      = valid_r;
        wrap_count_s = wrap_count_r;
        seq_error_s  = seq_error_r;
        overrun_s    = overrun_r;
        wrap_s       = 1'b0;
        accept_s     = valid_r & period_bus.period_ready;
        // For N=256 the 8-bit increment also matches 255->0, so wrap is tested first.
        inc_ok_s     = (counter == (prev_r + 8'd1)) && ({1'b0, counter} < N_EXT);

        case (state_r)
            SYNC: begin
                prev_s = counter;
                if (counter == 8'd0) begin
                    state_s   = TRACK;
                    run_len_s = 9'd1;
                end else begin
                    state_s = SYNC;
                end
            end
            TRACK: begin
                prev_s = counter;
                if ((counter == 8'd0) && (prev_r == LAST)) begin
                    wrap_s    = 1'b1;
                    run_len_s = 9'd1;
                end else if (inc_ok_s) begin
                    run_len_s = run_len_r + 9'd1;
                end else begin
                    seq_error_s = 1'b1;
                    if (STOP_ON_ERROR) begin
                        state_s = HALT;
                    end else if (counter == 8'd0) begin
                        state_s   = TRACK;
                        run_len_s = 9'd1;
                    end else begin
                        state_s   = SYNC;
                        run_len_s = 9'd0;
                    end
                end
            end
            HALT: begin
                state_s = HALT;
            end
            default: begin
                state_s = SYNC;
            end
        endcase

        if (wrap_s) begin
            if (!valid_r || accept_s) begin
                period_s = run_len_r;
                valid_s  = 1'b1;
            end else begin
                overrun_s = 1'b1;
            end
            if (wrap_count_r != 16'hFFFF) begin
                wrap_count_s = wrap_count_r + 16'd1;
            end else begin
                wrap_count_s = wrap_count_r;
            end
        end else if (accept_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= SYNC;
            prev_r       <= 8'd0;
            run_len_r    <= 9'd0;
            period_r     <= 9'd0;
            valid_r      <= 1'b0;
            wrap_count_r <= 16'd0;
            seq_error_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            prev_r       <= prev_s;
            run_len_r    <= run_len_s;
            period_r     <= period_s;
            valid_r      <= valid_s;
            wrap_count_r <= wrap_count_s;
            seq_error_r  <= seq_error_s;
            overrun_r    <= overrun_s;
        end
    end

    assign period_bus.period       = period_r;
    assign period_bus.period_valid = valid_r;
    assign wrap_count              = wrap_count_r;
    assign seq_error               = seq_error_r;
    assign overrun                 = overrun_r;
    assign state                   = state_r;
endmodule
